// File: rtl/legv8_pkg.sv
// Shared LEGv8 store-path definitions: store size codes, serializer state
// encoding and the size-code to last-byte-index mapping.
package legv8_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Index of the final byte for a size code: (1 << size) - 1.
  function automatic logic [IDX_W-1:0] size_last_idx(input logic [1:0] sz);
    logic [IDX_W-1:0] last;
    case (sz)
      SZ_BYTE:   last = 3'd0;
      SZ_HALF:   last = 3'd1;
      SZ_WORD:   last = 3'd3;
      default:   last = 3'd7;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/store_byte_serializer_byte_shift_reg.sv
// Load / shift-right-by-8 register with hold; the low byte is the byte
// currently offered to memory.
module byte_shift_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [7:0]        dout
);

  logic [DATA_W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {8'h00, sr_q[DATA_W-1:8]};
    end
  end

  assign dout = sr_q[7:0];

endmodule

// File: rtl/store_byte_serializer.sv
// Narrows a STUR/STURW/STURH/STURB register value to 1/2/4/8 bytes and
// writes them little-endian, one per handshake, to a byte-wide memory port.
module store_byte_serializer
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              accept, fire, last_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    fire      = 1'b0;
    last_byte = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept = req_valid;
        if (accept) state_d = ST_SEND;
      end
      ST_SEND: begin
        fire      = mem_ready;
        last_byte = fire && (idx_q == last_q);
        if (last_byte) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // addr_q walks base+idx directly; natural ADDR_W overflow gives the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_byte;
      if (accept) begin
        addr_q <= req_addr;
        idx_q  <= '0;
        last_q <= size_last_idx(req_size);
      end else if (fire) begin
        addr_q <= addr_q + ADDR_W'(1);
        idx_q  <= idx_q + 3'd1;
      end
    end
  end

  byte_shift_reg #(
    .DATA_W (DATA_W)
  ) u_sreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (fire),
    .din   (req_data),
    .dout  (mem_wdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign mem_we    = (state_q == ST_SEND);
  assign busy      = (state_q == ST_SEND);
  assign mem_addr  = addr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_store_byte_serializer.sv
// Scoreboard bench for store_byte_serializer: stimulus queues expected
// (address, byte) writes; a negedge monitor pops them on every handshake.
module tb_store_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        mem_we;
  logic        mem_ready;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  errors   = 0;
  int  done_cnt = 0;

  always #5 clk = ~clk;

  store_byte_serializer #(
    .ADDR_W (64),
    .DATA_W (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.a = a + 64'(i);
      e.d = d[8*i +: 8];
      sb_q.push_back(e);
    end
  endtask

  // Monitor: every accepted byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (mem_we) begin
        chk("req_ready_low_in_send", 64'(req_ready), 64'd0);
        chk("busy_in_send", 64'(busy), 64'd1);
        if (mem_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_write", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            mon_e = sb_q.pop_front();
            chk("wr_addr", mem_addr, mon_e.a);
            chk("wr_data", 64'(mem_wdata), 64'(mon_e.d));
          end
        end
      end
    end
  end

  // One isolated store; done latency measured from the acceptance edge.
  task automatic run_store(input logic [63:0] a, input logic [63:0] d,
                           input logic [1:0] sz, input bit stall);
    int n;
    int cyc;
    n = 1 << sz;
    @(posedge clk); #1;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_addr  = a;
    req_data  = d;
    req_size  = sz;
    req_valid = 1'b1;
    mem_ready = !stall;
    push_exp(a, d, n);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_size  = ~sz;
    req_data  = ~d;
    cyc = 1;
    if (stall) begin
      chk("stall_addr0", mem_addr, a);
      chk("stall_data0", 64'(mem_wdata), 64'(d[7:0]));
      @(posedge clk); #1;
      cyc = 2;
      mem_ready = 1'b1;
      chk("held_we", 64'(mem_we), 64'd1);
      chk("held_addr0", mem_addr, a);
      chk("held_data0", 64'(mem_wdata), 64'(d[7:0]));
    end
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_latency", 64'(cyc), 64'(n + 1 + int'(stall)));
    chk("req_ready_with_done", 64'(req_ready), 64'd1);
    chk("no_we_after_done", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    chk("done_single_pulse", 64'(done), 64'd0);
    chk("no_we_idle", 64'(mem_we), 64'd0);
  endtask

  initial begin
    int cyc;
    int d0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    mem_ready = 1'b1;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    #10 rst_n = 1'b1;

    // STURB, STUR, STURH with backpressure, STURW across address wrap
    run_store(64'h100, 64'h1122334455667788, 2'b00, 1'b0);
    run_store(64'h200, 64'h0123456789ABCDEF, 2'b11, 1'b0);
    run_store(64'h10, 64'hBEEF, 2'b01, 1'b1);
    run_store(64'hFFFF_FFFF_FFFF_FFFE, 64'hDEADBEEF, 2'b10, 1'b0);

    // Back-to-back STURWs with req_valid held high
    @(posedge clk); #1;
    req_addr  = 64'h400;
    req_data  = 64'h11223344_AABBCCDD;
    req_size  = 2'b10;
    req_valid = 1'b1;
    push_exp(64'h400, 64'h11223344_AABBCCDD, 4);
    @(posedge clk); #1;
    req_addr = 64'h500;
    req_data = 64'hCAFEF00D;
    push_exp(64'h500, 64'hCAFEF00D, 4);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_first_done", 64'(cyc), 64'd5);
    chk("b2b_ready_in_done", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_second_accepted", 64'(busy), 64'd1);
    chk("b2b_done_pulse", 64'(done), 64'd0);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_second_done", 64'(cyc), 64'd5);

    // Reset after the third byte of a STUR
    @(posedge clk); #1;
    req_addr  = 64'h300;
    req_data  = 64'h8877665544332211;
    req_size  = 2'b11;
    req_valid = 1'b1;
    push_exp(64'h300, 64'h8877665544332211, 8);
    @(posedge clk); #1;
    req_valid = 1'b0;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_we", 64'(mem_we), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_mem_addr", mem_addr, 64'd0);
    chk("abort_bytes_left", 64'(sb_q.size()), 64'd5);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    run_store(64'h600, 64'hA5A5_0000_0000_3C5A, 2'b01, 1'b0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
